item_collision_scanner: RTL and testbench

Downstream consumer of the rope controller's hook-end coordinates. On each `start` strobe it latches the hook tip (`hook_x`, `hook_y`) and scans the item table (stones, gold, diamonds) one entry per clock through a synchronous-read port. It reports the lowest-index item whose bounding box contains the hook tip. The rope controller uses the result to switch from extending to retracting and to pick line speed from the item's type and size.

---
 rtl/item_collision_scanner.sv | 168 ++++++++++++++++
 tb/tb_item_collision_scanner.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/item_collision_scanner.sv
// item_collision_scanner: scans the item table one entry per clock and reports the lowest-index item containing the hook tip.
// Optional macro COLLISION_AUTO_CLEAR_EN: in the DONE cycle of a hit, write the hit record back with its valid bit cleared.
module item_collision_scanner #(
  parameter int ITEM_COUNT = 16,
  parameter int IDX_W      = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic             start,
  input  logic [8:0]       hook_x,
  input  logic [7:0]       hook_y,
  output logic [IDX_W-1:0] item_addr,
  input  logic [21:0]      item_rdata,
  output logic             item_we,
  output logic [21:0]      item_wdata,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [IDX_W-1:0] hit_index,
  output logic [1:0]       hit_type,
  output logic [1:0]       hit_size
);

  localparam int CW = IDX_W + 1;
  localparam logic [CW-1:0]    CNT_END  = CW'(ITEM_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITEM_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [8:0]        hx_reg;
  logic [7:0]        hy_reg;
  logic              hit_reg;
  logic [IDX_W-1:0]  hit_index_reg;
  logic [1:0]        hit_type_reg;
  logic [1:0]        hit_size_reg;
`ifdef COLLISION_AUTO_CLEAR_EN
  logic [20:0]       hit_rec_reg;
`endif

  logic              accept;
  logic              cmp_valid;
  logic              match;
  logic [IDX_W-1:0]  cmp_idx;
  logic signed [9:0] dx, dy;
  logic [9:0]        adx, ady, radius;

  assign accept    = (state_reg == IDLE) && start && enable;
  // cnt_reg counts SCAN cycles; the record compared now was addressed one cycle earlier
  assign cmp_valid = (state_reg == SCAN) && (cnt_reg != '0);
  assign cmp_idx   = cnt_reg[IDX_W-1:0] - IDX_W'(1);

  always_comb begin
    dx = $signed({1'b0, hx_reg}) - $signed({1'b0, item_rdata[16:8]});
    dy = $signed({2'b00, hy_reg}) - $signed({2'b00, item_rdata[7:0]});
    adx = dx[9] ? -dx : dx;
    ady = dy[9] ? -dy : dy;
    case (item_rdata[18:17])
      2'd0:    radius = 10'd3;
      2'd1:    radius = 10'd5;
      2'd2:    radius = 10'd8;
      default: radius = 10'd12;
    endcase
    match = item_rdata[21] && (item_rdata[20:19] != 2'b00) &&
            (adx <= radius) && (ady <= radius);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SCAN;
          cnt_next   = '0;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (cmp_valid && match) begin
          state_next = DONE;
        end else if (cnt_reg >= CNT_END) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hx_reg        <= '0;
      hy_reg        <= '0;
      hit_reg       <= 1'b0;
      hit_index_reg <= '0;
      hit_type_reg  <= '0;
      hit_size_reg  <= '0;
`ifdef COLLISION_AUTO_CLEAR_EN
      hit_rec_reg   <= '0;
`endif
    end else if (accept) begin
      hx_reg        <= hook_x;
      hy_reg        <= hook_y;
      hit_reg       <= 1'b0;
      hit_index_reg <= '0;
      hit_type_reg  <= '0;
      hit_size_reg  <= '0;
`ifdef COLLISION_AUTO_CLEAR_EN
      hit_rec_reg   <= '0;
`endif
    end else if ((state_reg != IDLE) && !enable) begin
      // an aborted scan drops hit but leaves the other fields as they were
      hit_reg <= 1'b0;
    end else if (cmp_valid && match) begin
      hit_reg       <= 1'b1;
      hit_index_reg <= cmp_idx;
      hit_type_reg  <= item_rdata[20:19];
      hit_size_reg  <= item_rdata[18:17];
`ifdef COLLISION_AUTO_CLEAR_EN
      hit_rec_reg   <= item_rdata[20:0];
`endif
    end
  end

  always_comb begin
    item_addr  = '0;
    item_we    = 1'b0;
    item_wdata = '0;
    if (state_reg == SCAN) begin
      item_addr = (cnt_reg >= CNT_END) ? LAST_IDX : cnt_reg[IDX_W-1:0];
    end
`ifdef COLLISION_AUTO_CLEAR_EN
    if ((state_reg == DONE) && enable && hit_reg) begin
      item_addr  = hit_index_reg;
      item_we    = 1'b1;
      item_wdata = {1'b0, hit_rec_reg};
    end
`endif
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE) && enable;
  assign hit       = hit_reg;
  assign hit_index = hit_index_reg;
  assign hit_type  = hit_type_reg;
  assign hit_size  = hit_size_reg;

endmodule

// File: tb/tb_item_collision_scanner.sv
// Testbench for item_collision_scanner: randomized and directed scans checked against a table-walking reference model.
module tb_item_collision_scanner;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clock = 1'b0;
  logic          resetn;
  logic          enable;
  logic          start;
  logic [8:0]    hook_x;
  logic [7:0]    hook_y;
  logic [IW-1:0] item_addr;
  logic [21:0]   item_rdata;
  logic          item_we;
  logic [21:0]   item_wdata;
  logic          busy;
  logic          done;
  logic          hit;
  logic [IW-1:0] hit_index;
  logic [1:0]    hit_type;
  logic [1:0]    hit_size;

  logic [21:0] mem     [N];
  logic [21:0] ref_tab [N];
  int n_checks = 0;
  int n_fail   = 0;

  item_collision_scanner #(.ITEM_COUNT(N), .IDX_W(IW)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .start(start),
    .hook_x(hook_x), .hook_y(hook_y), .item_addr(item_addr),
    .item_rdata(item_rdata), .item_we(item_we), .item_wdata(item_wdata),
    .busy(busy), .done(done), .hit(hit), .hit_index(hit_index),
    .hit_type(hit_type), .hit_size(hit_size)
  );

  always #5 clock = ~clock;

  // synchronous-read item table; a write lands after the read of the same edge
  always @(posedge clock) begin
    item_rdata <= mem[item_addr];
    if (item_we) mem[item_addr] = item_wdata;
  end

  function automatic logic [21:0] mk(input int v, input int t, input int s, input int x, input int y);
    return {1'(v), 2'(t), 2'(s), 9'(x), 8'(y)};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // first table entry (lowest index) whose box contains the hook, or -1
  function automatic int model_idx(input int hx, input int hy);
    int r;
    for (int i = 0; i < N; i++) begin
      case (int'(ref_tab[i][18:17]))
        0: r = 3;
        1: r = 5;
        2: r = 8;
        default: r = 12;
      endcase
      if (ref_tab[i][21] && ref_tab[i][20:19] != 2'b00 &&
          iabs(hx - int'(ref_tab[i][16:8])) <= r &&
          iabs(hy - int'(ref_tab[i][7:0])) <= r)
        return i;
    end
    return -1;
  endfunction

  task automatic clear_tab();
    for (int i = 0; i < N; i++) ref_tab[i] = '0;
  endtask

  task automatic load_tab();
    for (int i = 0; i < N; i++) mem[i] = ref_tab[i];
  endtask

  task automatic kick(input int hx, input int hy);
    @(negedge clock);
    start = 1'b1; hook_x = 9'(hx); hook_y = 8'(hy);
    @(negedge clock);
    start = 1'b0;
    hook_x = 9'($urandom_range(319));
    hook_y = 8'($urandom_range(239));
  endtask

  // run one scan, checking per-cycle busy/address and the result in the done cycle
  task automatic do_scan(input int hx, input int hy, input string name,
                         input bit ign_done, input int restart_cyc);
    int exp_idx, exp_cyc, got, exp_addr;
    logic exp_hit;
    logic [IW-1:0] exp_hidx;
    logic [1:0] exp_t, exp_s;
    exp_idx  = model_idx(hx, hy);
    exp_hit  = (exp_idx >= 0);
    exp_cyc  = exp_hit ? exp_idx + 2 : N + 1;
    exp_hidx = exp_hit ? IW'(exp_idx) : '0;
    exp_t    = exp_hit ? ref_tab[exp_idx][20:19] : 2'b00;
    exp_s    = exp_hit ? ref_tab[exp_idx][18:17] : 2'b00;
    kick(hx, hy);
    got = -1;
    for (int cyc = 0; cyc < N + 6; cyc++) begin
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b want 1", name, cyc, busy);
        break;
      end
      if (cyc < exp_cyc) begin
        exp_addr = (cyc < N) ? cyc : N - 1;
        n_checks++;
        if (item_addr !== IW'(exp_addr)) begin
          n_fail++;
          $display("FAIL %s item_addr cycle %0d: got %0d want %0d", name, cyc, item_addr, exp_addr);
        end
      end
      if (done === 1'b1) begin
        got = cyc;
        break;
      end
      if (cyc == restart_cyc) begin
        start = 1'b1; hook_x = 9'd250; hook_y = 8'd200;
      end
      if (cyc == restart_cyc + 1) start = 1'b0;
      @(negedge clock);
    end
    start = 1'b0;
    n_checks++;
    if (got != exp_cyc) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, got, exp_cyc);
    end
    n_checks++;
    if ({hit, hit_index, hit_type, hit_size} !== {exp_hit, exp_hidx, exp_t, exp_s}) begin
      n_fail++;
      $display("FAIL %s result: got hit=%b idx=%0d type=%0d size=%0d want hit=%b idx=%0d type=%0d size=%0d",
               name, hit, hit_index, hit_type, hit_size, exp_hit, exp_hidx, exp_t, exp_s);
    end
`ifdef COLLISION_AUTO_CLEAR_EN
    if (exp_hit) begin
      n_checks++;
      if ({item_we, item_addr, item_wdata} !== {1'b1, exp_hidx, 1'b0, ref_tab[exp_idx][20:0]}) begin
        n_fail++;
        $display("FAIL %s auto_clear: got we=%b addr=%0d wdata=%h want we=1 addr=%0d wdata=%h",
                 name, item_we, item_addr, item_wdata, exp_hidx, {1'b0, ref_tab[exp_idx][20:0]});
      end
      ref_tab[exp_idx][21] = 1'b0;
    end else begin
      n_checks++;
      if (item_we !== 1'b0) begin
        n_fail++;
        $display("FAIL %s item_we_nohit: got %b want 0", name, item_we);
      end
    end
`else
    n_checks++;
    if ({item_we, item_wdata, item_addr} !== '0) begin
      n_fail++;
      $display("FAIL %s write_port: got we=%b wdata=%h addr=%0d want all 0", name, item_we, item_wdata, item_addr);
    end
`endif
    $display("scan %s hook=(%0d,%0d) done_cycle=%0d hit=%b idx=%0d type=%0d size=%0d",
             name, hx, hy, got, hit, hit_index, hit_type, hit_size);
    if (ign_done) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n_checks++;
      if ({busy, done, hit} !== {1'b0, 1'b0, exp_hit}) begin
        n_fail++;
        $display("FAIL %s after_done: got busy=%b done=%b hit=%b want 0 0 %b", name, busy, done, hit, exp_hit);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; start = 1'b0; hook_x = '0; hook_y = '0;
    clear_tab(); load_tab();
    repeat (3) @(negedge clock);
    n_checks++;
    if ({busy, done, hit, hit_index, hit_type, hit_size, item_addr, item_we, item_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got busy=%b done=%b hit=%b idx=%0d addr=%0d we=%b want all 0",
               busy, done, hit, hit_index, item_addr, item_we);
    end
    resetn = 1'b1; enable = 1'b1;
    kick(10, 10);
    repeat (3) @(negedge clock);
    n_checks++;
    if ({busy, item_addr} !== {1'b1, IW'(3)}) begin
      n_fail++;
      $display("FAIL reset_midscan_pre: got busy=%b addr=%0d want 1 3", busy, item_addr);
    end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, hit, hit_index, hit_type, hit_size, item_addr, item_we, item_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got busy=%b done=%b hit=%b addr=%0d want all 0", busy, done, hit, item_addr);
    end
    @(negedge clock);
    resetn = 1'b1;
    ref_tab[5] = mk(1, 2, 1, 100, 120);
    load_tab();
    do_scan(104, 117, "after_reset", 1'b0, -1);
  endtask

  task automatic test_single_hit();
    clear_tab();
    ref_tab[5] = mk(1, 2, 1, 100, 120);
    load_tab();
    do_scan(104, 117, "gold5", 1'b1, -1);
  endtask

  task automatic test_lowest_index();
    clear_tab();
    ref_tab[2] = mk(1, 1, 0, 200, 50);
    ref_tab[9] = mk(1, 3, 2, 201, 52);
    load_tab();
    do_scan(200, 50, "lowest", 1'b1, -1);
  endtask

  task automatic test_no_hit();
    clear_tab();
    for (int i = 0; i < N; i++) ref_tab[i] = mk(0, 2, 3, 100, 100);
    load_tab();
    do_scan(100, 100, "all_invalid", 1'b1, -1);
    clear_tab();
    ref_tab[7] = mk(1, 0, 3, 100, 100);
    load_tab();
    do_scan(100, 100, "type_none", 1'b1, -1);
  endtask

  task automatic test_boundary();
    clear_tab();
    ref_tab[4] = mk(1, 1, 3, 12, 0);
    ref_tab[8] = mk(1, 2, 3, 310, 235);
    load_tab();
    do_scan(0, 12, "edge_r", 1'b1, -1);
    clear_tab();
    ref_tab[4] = mk(1, 1, 3, 12, 0);
    ref_tab[8] = mk(1, 2, 3, 310, 235);
    load_tab();
    do_scan(0, 13, "edge_r_plus1", 1'b1, -1);
    do_scan(319, 3, "far_corner", 1'b1, -1);
  endtask

  task automatic test_start_ignored();
    clear_tab();
    ref_tab[1]  = mk(1, 3, 3, 250, 200);
    ref_tab[12] = mk(1, 1, 2, 50, 60);
    load_tab();
    do_scan(50, 60, "restart_mid", 1'b1, 3);
  endtask

  task automatic test_enable_drop();
    clear_tab();
    ref_tab[10] = mk(1, 2, 2, 150, 100);
    load_tab();
    kick(150, 100);
    for (int cyc = 0; cyc < 12; cyc++) begin
      n_checks++;
      if ({busy, done} !== {(cyc <= 4) ? 1'b1 : 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL enable_drop cycle %0d: got busy=%b done=%b want %b 0", cyc, busy, done, cyc <= 4);
      end
      if (cyc == 4) enable = 1'b0;
      @(negedge clock);
    end
    n_checks++;
    if (hit !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_drop_hit: got %b want 0", hit);
    end
    $display("scan enable_drop hook=(150,100) busy=%b hit=%b", busy, hit);
    enable = 1'b1;
  endtask

  task automatic test_back_to_back();
    clear_tab();
    ref_tab[3] = mk(1, 1, 1, 30, 40);
    ref_tab[6] = mk(1, 3, 0, 280, 20);
    load_tab();
    do_scan(31, 42, "b2b_first", 1'b0, -1);
    do_scan(280, 21, "b2b_second", 1'b0, -1);
    do_scan(160, 120, "b2b_miss", 1'b1, -1);
  endtask

  task automatic test_auto_clear();
    clear_tab();
    ref_tab[5] = mk(1, 2, 1, 100, 120);
    load_tab();
    do_scan(104, 117, "grab", 1'b1, -1);
    do_scan(104, 117, "rescan", 1'b1, -1);
  endtask

  task automatic test_random();
    int hx, hy, x, y;
    for (int it = 0; it < 20; it++) begin
      hx = int'($urandom_range(319));
      hy = int'($urandom_range(239));
      for (int i = 0; i < N; i++) begin
        x = hx + int'($urandom_range(30)) - 15;
        y = hy + int'($urandom_range(30)) - 15;
        x = (x < 0) ? 0 : (x > 319) ? 319 : x;
        y = (y < 0) ? 0 : (y > 239) ? 239 : y;
        ref_tab[i] = mk(($urandom_range(3) != 0) ? 1 : 0, int'($urandom_range(3)),
                        int'($urandom_range(3)), x, y);
      end
      load_tab();
      do_scan(hx, hy, $sformatf("rand%0d", it), it[0], (it % 3 == 0) ? 2 : -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_lowest_index();
    test_no_hit();
    test_boundary();
    test_start_ignored();
    test_enable_drop();
    test_back_to_back();
    test_auto_clear();
    test_random();
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
